async_fifo_wr_ctrl: RTL and testbench

Write-side controller of the asynchronous FIFO, sitting in the W_CLK domain. It drives W_CLK_EN and W_ADDR into the dual-clock FIFO RAM and exports a registered Gray-coded write pointer to the read domain. It synchronizes the read-domain Gray pointer into W_CLK and derives FULL, ALMOST_FULL, fill level and a sticky overflow flag. The producer writes by asserting W_INC with data presented directly to the RAM.

---
 rtl/async_fifo_pkg.sv | 28 ++
 rtl/fifo_ptr_sync.sv | 25 ++
 rtl/async_fifo_wr_ctrl.sv | 81 ++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
package async_fifo_pkg;

  // Widest pointer the helpers accept. Callers zero-extend into this width and truncate the result back.
  localparam int unsigned GRAY_MAX_W = 32;

  // Pointer width for a given RAM address width. The extra MSB separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Binary to Gray. This is correct for any width up to GRAY_MAX_W when the input is zero-extended.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as a prefix XOR from the MSB down. Zero-extended inputs decode unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded FIFO pointer crossing clock domains.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // Plain shift chain with no logic between flops. Only one bit of d changes at a time, so the capture is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO. It tracks the write pointer,
// exports it in Gray code and derives full, almost-full, level and overflow.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST_n,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   R_PTR_GRAY,
  input  logic                  OVF_CLR,
  output logic                  W_CLK_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  // Full pattern: the synchronized read pointer with its top two Gray bits inverted.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (PTR_W - 2);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rq_sync;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] level_next;

  // Bring the read-domain Gray pointer into W_CLK.
  fifo_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (W_CLK),
    .rst_n (W_RST_n),
    .d     (R_PTR_GRAY),
    .q     (rq_sync)
  );

  // RAM-facing write enable and address. A write is dropped while FULL.
  assign W_CLK_EN = W_INC & ~FULL;
  assign W_ADDR   = wbin[ADDR_WIDTH-1:0];

  // Next-pointer, Gray and occupancy terms. The level is measured against the stale synchronized read pointer, so it can only overestimate.
  assign wbin_next  = wbin + PTR_W'(W_CLK_EN);
  assign gray_next  = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));
  assign rbin_sync  = PTR_W'(gray2bin(GRAY_MAX_W'(rq_sync)));
  assign level_next = wbin_next - rbin_sync;

  // Pointer, status and sticky overflow registers.
  always_ff @(posedge W_CLK or negedge W_RST_n) begin
    if (!W_RST_n) begin
      wbin        <= '0;
      W_PTR_GRAY  <= '0;
      FULL        <= 1'b0;
      ALMOST_FULL <= 1'b0;
      W_LEVEL     <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      W_PTR_GRAY  <= gray_next;
      FULL        <= (gray_next == (rq_sync ^ FULL_MASK));
      ALMOST_FULL <= (level_next >= AFULL_LVL);
      W_LEVEL     <= level_next;
      if (W_INC && FULL) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed scoreboard bench for async_fifo_wr_ctrl with default parameters
// (8-entry FIFO, 2-stage synchronizer, almost-full at 6).
module tb_async_fifo_wr_ctrl;

  typedef struct {
    string      name;
    logic [6:0] mask;   // 0 en, 1 addr, 2 gray, 3 full, 4 afull, 5 level, 6 ovf
    logic       en;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ovf;
  } exp_t;

  localparam logic [6:0] ALL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] rptr = 4'd0;

  logic       w_clk_en;
  logic [2:0] w_addr;
  logic [3:0] w_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
  logic       overflow;

  exp_t scb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] g8 [8];

  async_fifo_wr_ctrl dut (
    .W_CLK       (clk),
    .W_RST_n     (rst_n),
    .W_INC       (inc),
    .R_PTR_GRAY  (rptr),
    .OVF_CLR     (clr),
    .W_CLK_EN    (w_clk_en),
    .W_ADDR      (w_addr),
    .W_PTR_GRAY  (w_ptr_gray),
    .FULL        (full),
    .ALMOST_FULL (almost_full),
    .W_LEVEL     (w_level),
    .OVERFLOW    (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string nm, input logic [6:0] m, input logic en,
                              input logic [2:0] a, input logic [3:0] g, input logic f,
                              input logic af, input logic [3:0] lv, input logic ov);
    exp_t e;
    e.name = nm; e.mask = m; e.en = en; e.addr = a; e.gray = g;
    e.full = f; e.afull = af; e.level = lv; e.ovf = ov;
    return e;
  endfunction

  function automatic logic [3:0] gray4(input int unsigned b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input string fld, input logic m,
                     input logic [3:0] act, input logic [3:0] exp);
    if (m) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, exp, $time);
      end
    end
  endtask

  // Monitor: compares the DUT against the next expectation mid-cycle, or right after an async reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        chk(e.name, "en",    e.mask[0], 4'(w_clk_en),    4'(e.en));
        chk(e.name, "addr",  e.mask[1], 4'(w_addr),      4'(e.addr));
        chk(e.name, "gray",  e.mask[2], w_ptr_gray,      e.gray);
        chk(e.name, "full",  e.mask[3], 4'(full),        4'(e.full));
        chk(e.name, "afull", e.mask[4], 4'(almost_full), 4'(e.afull));
        chk(e.name, "level", e.mask[5], w_level,         e.level);
        chk(e.name, "ovf",   e.mask[6], 4'(overflow),    4'(e.ovf));
      end
    end
  end

  // Drive one cycle of inputs shortly after the edge, and queue the state expected mid-cycle.
  task automatic cyc(input logic i_inc, input logic [3:0] i_r, input logic i_clr, input exp_t e);
    @(posedge clk);
    #2;
    inc  = i_inc;
    rptr = i_r;
    clr  = i_clr;
    scb.push_back(e);
  endtask

  // Assert reset away from any edge, check that everything is cleared without a clock, then release.
  task automatic reset_pulse(input string nm);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    inc   = 1'b0;
    clr   = 1'b0;
    rptr  = 4'd0;
    scb.push_back(mk(nm, ALL, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0));
    #1 -> sample_ev;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    g8[0] = 4'd0; g8[1] = 4'd1; g8[2] = 4'd3; g8[3] = 4'd2;
    g8[4] = 4'd6; g8[5] = 4'd7; g8[6] = 4'd5; g8[7] = 4'd4;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // A few writes so that the reset has something to clear
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 4'd0, 1'b0, mk("warm", ALL, 1'b1, 3'(k), g8[k], 1'b0, 1'b0, 4'(k), 1'b0));

    // 1: asynchronous reset mid-cycle, then idle
    reset_pulse("t1_reset");
    cyc(1'b0, 4'd0, 1'b0, mk("t1_idle", ALL, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0));

    // 2: fill the FIFO with the read pointer held at 0
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 4'd0, 1'b0, mk("t2_fill", ALL, 1'b1, 3'(k), g8[k], 1'b0, (k >= 6), 4'(k), 1'b0));

    // 3: writes while full are dropped; overflow set, clear, and set-beats-clear
    cyc(1'b1, 4'd0, 1'b0, mk("t3_full",     ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b0));
    cyc(1'b1, 4'd0, 1'b0, mk("t3_ovf_set",  ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b0, 4'd0, 1'b1, mk("t3_ovf_hold", ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b1, 4'd0, 1'b1, mk("t3_ovf_clr",  ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b0));
    cyc(1'b0, 4'd0, 1'b0, mk("t3_set_wins", ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));

    // 4: one read; FULL drops exactly three edges after the read pointer moves
    cyc(1'b0, 4'd1, 1'b0, mk("t4_e0", ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b0, 4'd1, 1'b0, mk("t4_e1", ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b0, 4'd1, 1'b0, mk("t4_e2", ALL, 1'b0, 3'd0, 4'd12, 1'b1, 1'b1, 4'd8, 1'b1));
    cyc(1'b0, 4'd1, 1'b0, mk("t4_e3", ALL, 1'b0, 3'd0, 4'd12, 1'b0, 1'b1, 4'd7, 1'b1));
    cyc(1'b1, 4'd1, 1'b1, mk("t4_en", ALL, 1'b1, 3'd0, 4'd12, 1'b0, 1'b1, 4'd7, 1'b1));

    // 5: 20-write stream with the reader consuming right behind the writer, across the pointer wrap
    reset_pulse("t5_reset");
    for (int i = 0; i < 20; i++)
      cyc(1'b1, gray4(i % 16), 1'b0,
          mk("t5_stream", ALL, 1'b1, 3'(i % 8), gray4(i % 16), 1'b0, 1'b0,
             4'((i < 3) ? i : 3), 1'b0));
    cyc(1'b0, gray4(4), 1'b0, mk("t5_drain", ALL, 1'b0, 3'd4, 4'd6, 1'b0, 1'b0, 4'd3, 1'b0));

    // 6: reset after five writes; the next write starts again at address 0
    reset_pulse("t6_pre");
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 4'd0, 1'b0, mk("t6_wr", ALL, 1'b1, 3'(k), g8[k], 1'b0, 1'b0, 4'(k), 1'b0));
    reset_pulse("t6_reset");
    cyc(1'b1, 4'd0, 1'b0, mk("t6_first", ALL, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0));
    cyc(1'b0, 4'd0, 1'b0, mk("t6_after", ALL, 1'b0, 3'd1, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0));

    // Let the monitor drain the scoreboard, within a bounded number of cycles
    for (int w = 0; w < 10 && scb.size() > 0; w++) @(posedge clk);
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", scb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
